weight_load_ctrl: RTL

Sequencer that streams per-layer convolution weights from an upstream 16-bit valid/ready source into `local_mem_weight`. It drives that memory's write port (`write_weight_signal`, `write_weight_data`, `write_weight_addr`), its `weight_fsm_cs` layer code and `weight_store_done`. It holds each layer's weights until the compute engine reports the layer finished, then loads the next layer: L1 → L2 → L4 → L5 → L7 → FINISH.

---
 rtl/weight_load_ctrl_if.sv | 21 ++
 rtl/weight_load_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/weight_load_ctrl_if.sv
// rtl/weight_load_ctrl_if.sv - upstream weight stream and weight-memory write port bundle
interface weight_load_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              write_weight_signal;
  logic [DATA_W-1:0] write_weight_data;
  logic [15:0]       write_weight_addr;

  modport master (
    output in_valid, in_data,
    input  in_ready, write_weight_signal, write_weight_data, write_weight_addr
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, write_weight_signal, write_weight_data, write_weight_addr
  );
endinterface

// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - per-layer weight load sequencer L1->L2->L4->L5->L7->FINISH
// Holds each layer resident until the compute engine reports it done.
module weight_load_ctrl #(
  parameter int DATA_W   = 16,
  parameter int L1_WORDS = 216,
  parameter int LC_WORDS = 576,
  parameter int L7_WORDS = 400
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                layer_done,
  weight_load_ctrl_if.slave   bus,
  output logic [3:0]          weight_fsm_cs,
  output logic                weight_store_done,
  output logic                weights_ready,
  output logic                all_done
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_L1     = 4'b0001,
    S_L2     = 4'b0010,
    S_L4     = 4'b0011,
    S_L5     = 4'b0100,
    S_L7     = 4'b0101,
    S_FINISH = 4'b1111
  } state_t;

  state_t            r_state;
  logic [15:0]       r_cnt;
  logic              r_loaded;
  logic              r_wr_sig;
  logic [DATA_W-1:0] r_wr_data;
  logic [15:0]       r_wr_addr;
  logic              r_last_wr;
  logic              r_store_done;
  logic              r_weights_ready;
  logic              r_all_done;

  logic              w_store_state;
  logic              w_in_ready;
  logic              w_hs;
  logic              w_last_hs;
  logic [15:0]       w_last_idx;
  state_t            w_next_layer;

  always_comb begin
    w_store_state = (r_state == S_L1) || (r_state == S_L2) || (r_state == S_L4) ||
                    (r_state == S_L5) || (r_state == S_L7);
    w_in_ready    = w_store_state && !r_loaded;
    w_hs          = bus.in_valid && w_in_ready;
    w_last_idx    = 16'(LC_WORDS - 1);
    w_next_layer  = S_FINISH;
    case (r_state)
      S_L1:    begin w_last_idx = 16'(L1_WORDS - 1); w_next_layer = S_L2; end
      S_L2:    w_next_layer = S_L4;
      S_L4:    w_next_layer = S_L5;
      S_L5:    w_next_layer = S_L7;
      S_L7:    begin w_last_idx = 16'(L7_WORDS - 1); w_next_layer = S_FINISH; end
      default: w_next_layer = S_FINISH;
    endcase
    w_last_hs = w_hs && (r_cnt == w_last_idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_loaded        <= 1'b0;
      r_wr_sig        <= 1'b0;
      r_wr_data       <= '0;
      r_wr_addr       <= '0;
      r_last_wr       <= 1'b0;
      r_store_done    <= 1'b0;
      r_weights_ready <= 1'b0;
      r_all_done      <= 1'b0;
    end else begin
      r_wr_sig     <= w_hs;
      r_wr_data    <= w_hs ? bus.in_data : '0;
      r_wr_addr    <= w_hs ? r_cnt : '0;
      // store_done trails the final write by one cycle so it lands after the memory commit
      r_last_wr    <= w_last_hs;
      r_store_done <= r_last_wr;
      case (r_state)
        S_IDLE, S_FINISH: begin
          if (start) begin
            r_state         <= S_L1;
            r_cnt           <= '0;
            r_loaded        <= 1'b0;
            r_weights_ready <= 1'b0;
            r_all_done      <= 1'b0;
          end
        end
        default: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 16'd1;
          end
          if (w_last_hs) begin
            r_loaded <= 1'b1;
          end
          if (r_last_wr) begin
            r_weights_ready <= 1'b1;
          end
          // weights_ready is still 0 while r_last_wr is set, so these never collide
          if (layer_done && r_weights_ready) begin
            r_state         <= w_next_layer;
            r_cnt           <= '0;
            r_loaded        <= 1'b0;
            r_weights_ready <= 1'b0;
            r_all_done      <= (w_next_layer == S_FINISH);
          end
        end
      endcase
    end
  end

  assign bus.in_ready            = w_in_ready;
  assign bus.write_weight_signal = r_wr_sig;
  assign bus.write_weight_data   = r_wr_data;
  assign bus.write_weight_addr   = r_wr_addr;
  assign weight_fsm_cs           = r_state;
  assign weight_store_done       = r_store_done;
  assign weights_ready           = r_weights_ready;
  assign all_done                = r_all_done;

endmodule
